fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage sitting directly upstream of the register bank and the decoder. Reads the current PC from the bank, fetches the instruction word over a req/ack memory handshake, and presents it to the decoder with a valid/ready handshake. Writes PC+step back through the bank's address-incrementer port and honours decoder-issued flushes on taken branches or PC writes.

## Interface
- PC_STEP, 4: increment applied to the fetched address.
- CNT_W, 16: width of the delivered-instruction counter.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- pc_in  in  32  current PC, driven by the bank's PC read port.
- mem_req  out  1  fetch request; held until acknowledged.
- mem_addr  out  32  fetch address; stable while mem_req=1.
- mem_ack  in  1  memory accepts; mem_rdata valid in the same cycle.
- mem_rdata  in  32  instruction word.
- instr  out  32  instruction register.
- instr_valid  out  1  instr holds an undelivered instruction.
- instr_ready  in  1  decoder accepts instr.
- flush  in  1  decoder redirected the PC; drop in-flight work.
- write_pc_en  out  1  one-cycle pulse to the bank's PC write enable.
- write_pc_data  out  32  next sequential PC.
- fetch_count  out  CNT_W  instructions delivered; wraps modulo 2^CNT_W.
- fetch_abort  out  1  misaligned fetch (see Configuration).

## Operation
- States: IDLE, FETCH, HOLD, ABORT (ABORT exists only with the macro).
- IDLE: on the next edge, latch mem_addr<=pc_in, set mem_req<=1, and go to FETCH. If flush is asserted, remain in IDLE.
- FETCH: on an edge with mem_ack=1:
  - instr<=mem_rdata, instr_valid<=1, mem_req<=0.
  - write_pc_en<=1 for exactly one cycle, with write_pc_data<=mem_addr+PC_STEP (mod 2^32).
  - Go to HOLD.
- FETCH with flush and no ack: set an internal discard flag and keep mem_req and mem_addr stable. The request is never withdrawn. On the eventual ack, drop the data, do not write the PC, clear discard, and go to IDLE.
- FETCH with flush and ack on the same edge: treat as discarded. Go to IDLE with no PC write.
- HOLD: on an edge with instr_ready=1, instr_valid<=0, fetch_count++, and go to IDLE.
- HOLD with flush: instr_valid<=0, no count, go to IDLE. If flush and instr_ready arrive on the same edge, flush wins and the count is not incremented.
- Passing through IDLE after every instruction guarantees that pc_in already reflects the bank write (either write_pc_en or the decoder's ALU PC write) before it is latched.
- instr retains its last value after delivery or flush; only instr_valid qualifies it.

## Timing
- Reset (async) sets state=IDLE, mem_req=0, mem_addr=0, instr=0, instr_valid=0, write_pc_en=0, write_pc_data=0, fetch_count=0, fetch_abort=0, and discard=0. Any outstanding memory request is abandoned.
- First mem_req rises on the first edge after reset deasserts.
- Ack edge to instr_valid=1: 0 cycles, since both are registered on the ack edge. write_pc_en is high in the cycle following the ack edge.
- Zero-wait memory with instr_ready tied high gives 3 cycles per instruction: FETCH, HOLD, IDLE.
- Accept edge to the next mem_req=1: 2 edges.
- Flush edge to the next mem_req=1: 2 edges from HOLD or IDLE. From FETCH, it is 2 edges after the ack.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - On the IDLE→FETCH edge, if pc_in[1:0]!=0, go to ABORT instead of FETCH: mem_req stays 0 and fetch_abort<=1.
  - ABORT is held until flush, which clears fetch_abort and goes to IDLE, or until reset.
- FETCH_ALIGN_CHECK_EN undefined:
  - mem_addr<={pc_in[31:2],2'b00}.
  - fetch_abort is tied to 0 and no ABORT state exists.

## Test plan
- Reset with pc_in=0x00000000, zero-wait memory returning 0xE3A00001, instr_ready=1 → mem_addr=0x0, instr=0xE3A00001, one write_pc_en pulse with write_pc_data=0x4, and fetch_count=1 after 3 cycles.
- Memory ack delayed 5 cycles at mem_addr=0x100 → mem_req stays high with mem_addr stable for all 5 cycles, exactly one write_pc_en pulse (data 0x104), and no instr_valid before the ack.
- instr_ready held low for 4 cycles in HOLD → instr_valid stays 1 and instr stays constant. No new mem_req until 2 edges after ready rises. fetch_count increments by exactly 1.
- flush asserted during an outstanding request at 0x200, ack 3 cycles later → no instr_valid and no write_pc_en. The next mem_addr equals the new pc_in (0x800).
- flush and instr_ready on the same edge in HOLD → instr_valid=0 and fetch_count unchanged. Separately, pc_in=0xFFFFFFFC → write_pc_data=0x00000000.
- With FETCH_ALIGN_CHECK_EN, pc_in=0x00000102 → fetch_abort=1 and mem_req=0 until flush; after flush with pc_in=0x104, fetching resumes. Without the macro, the same pc_in gives mem_addr=0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: latches PC, fetches over req/ack, hands the word to the decoder over valid/ready.
// Optional misaligned-fetch trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
   parameter int unsigned PC_STEP = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      pc_in,
   output logic             mem_req,
   output logic [31:0]      mem_addr,
   input  logic             mem_ack,
   input  logic [31:0]      mem_rdata,
   output logic [31:0]      instr,
   output logic             instr_valid,
   input  logic             instr_ready,
   input  logic             flush,
   output logic             write_pc_en,
   output logic [31:0]      write_pc_data,
   output logic [CNT_W-1:0] fetch_count,
   output logic             fetch_abort
);

   // Handshakes: memory transfer happens on an edge with mem_req=1 and mem_ack=1;
   // decoder transfer happens on an edge with instr_valid=1 and instr_ready=1.
`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_ABORT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;
`endif

   state_t             state_q, state_d;
   logic               mem_req_q, mem_req_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic [31:0]        instr_q, instr_d;
   logic               instr_valid_q, instr_valid_d;
   logic               write_pc_en_q, write_pc_en_d;
   logic [31:0]        write_pc_data_q, write_pc_data_d;
   logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
   logic               discard_q, discard_d;
`ifdef FETCH_ALIGN_CHECK_EN
   logic               fetch_abort_q, fetch_abort_d;
`endif

   always_comb begin
      state_d         = state_q;
      mem_req_d       = mem_req_q;
      mem_addr_d      = mem_addr_q;
      instr_d         = instr_q;
      instr_valid_d   = instr_valid_q;
      write_pc_en_d   = 1'b0;
      write_pc_data_d = write_pc_data_q;
      fetch_count_d   = fetch_count_q;
      discard_d       = discard_q;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_abort_d   = fetch_abort_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!flush) begin
`ifdef FETCH_ALIGN_CHECK_EN
               if (pc_in[1:0] != 2'b00) begin
                  fetch_abort_d = 1'b1;
                  state_d       = S_ABORT;
               end else begin
                  mem_addr_d = pc_in;
                  mem_req_d  = 1'b1;
                  state_d    = S_FETCH;
               end
`else
               mem_addr_d = pc_in & ~32'h3;
               mem_req_d  = 1'b1;
               state_d    = S_FETCH;
`endif
            end
         end
         S_FETCH: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               // A flush seen now or earlier in this request kills the returning word.
               if (flush || discard_q) begin
                  discard_d = 1'b0;
                  state_d   = S_IDLE;
               end else begin
                  instr_d         = mem_rdata;
                  instr_valid_d   = 1'b1;
                  write_pc_en_d   = 1'b1;
                  write_pc_data_d = mem_addr_q + 32'(PC_STEP);
                  state_d         = S_HOLD;
               end
            end else if (flush) begin
               discard_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (flush) begin
               instr_valid_d = 1'b0;
               state_d       = S_IDLE;
            end else if (instr_ready) begin
               instr_valid_d = 1'b0;
               fetch_count_d = fetch_count_q + CNT_W'(1);
               state_d       = S_IDLE;
            end
         end
`ifdef FETCH_ALIGN_CHECK_EN
         S_ABORT: begin
            if (flush) begin
               fetch_abort_d = 1'b0;
               state_d       = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         mem_req_q       <= 1'b0;
         mem_addr_q      <= 32'h0;
         instr_q         <= 32'h0;
         instr_valid_q   <= 1'b0;
         write_pc_en_q   <= 1'b0;
         write_pc_data_q <= 32'h0;
         fetch_count_q   <= '0;
         discard_q       <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         fetch_abort_q   <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         mem_req_q       <= mem_req_d;
         mem_addr_q      <= mem_addr_d;
         instr_q         <= instr_d;
         instr_valid_q   <= instr_valid_d;
         write_pc_en_q   <= write_pc_en_d;
         write_pc_data_q <= write_pc_data_d;
         fetch_count_q   <= fetch_count_d;
         discard_q       <= discard_d;
`ifdef FETCH_ALIGN_CHECK_EN
         fetch_abort_q   <= fetch_abort_d;
`endif
      end
   end

   assign mem_req       = mem_req_q;
   assign mem_addr      = mem_addr_q;
   assign instr         = instr_q;
   assign instr_valid   = instr_valid_q;
   assign write_pc_en   = write_pc_en_q;
   assign write_pc_data = write_pc_data_q;
   assign fetch_count   = fetch_count_q;
`ifdef FETCH_ALIGN_CHECK_EN
   assign fetch_abort   = fetch_abort_q;
`else
   assign fetch_abort   = 1'b0;
`endif

endmodule
